// File: rtl/spi_slave.sv
// SPI mode-0 target run entirely from clk: sclk/mosi/ss_n are oversampled,
// with an RX byte output and a single-entry TX holding register.
module spi_slave #(
    parameter int          SYNC_FLOPS = 2,
    parameter logic [7:0]  TX_DEFAULT = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, state_next;

    logic [SYNC_FLOPS-1:0] sclk_sr, mosi_sr, ss_sr;
    logic       sclk_s, mosi_s, ss_s;
    logic       sclk_q, ss_q;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic       rx_done;
    logic [7:0] tx_shift;
    logic [7:0] tx_next;
    logic [7:0] hold_data;
    logic       hold_full;
    logic       hold_write;
    logic       selected;

    logic       start, stop, rx_shift_en, tx_shift_en, consume;

    // Synchronizer chains; preloads match an idle, deselected bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sr <= '0;
            mosi_sr <= '0;
            ss_sr   <= '1;
            sclk_q  <= 1'b0;
            ss_q    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_FLOPS-2:0], sclk};
            mosi_sr <= {mosi_sr[SYNC_FLOPS-2:0], mosi};
            ss_sr   <= {ss_sr[SYNC_FLOPS-2:0], ss_n};
            sclk_q  <= sclk_s;
            ss_q    <= ss_s;
        end
    end

    assign sclk_s    = sclk_sr[SYNC_FLOPS-1];
    assign mosi_s    = mosi_sr[SYNC_FLOPS-1];
    assign ss_s      = ss_sr[SYNC_FLOPS-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign ss_fall   = ~ss_s & ss_q;
    assign ss_rise   = ss_s & ~ss_q;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = ACTIVE;
            ACTIVE:  if (ss_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Deselect wins over a coincident sclk edge, so a trailing sclk fall that
    // lands with ss_n rising does not consume the holding register.
    always_comb begin
        start       = 1'b0;
        stop        = 1'b0;
        rx_shift_en = 1'b0;
        tx_shift_en = 1'b0;
        consume     = 1'b0;
        case (state)
            IDLE: begin
                start   = ss_fall;
                consume = ss_fall;
            end
            ACTIVE: begin
                stop        = ss_rise;
                rx_shift_en = ~ss_rise & sclk_rise;
                tx_shift_en = ~ss_rise & sclk_fall & (bit_cnt != 3'd0);
                consume     = ~ss_rise & sclk_fall & (bit_cnt == 3'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            rx_byte       <= '0;
            rx_done       <= 1'b0;
            rx_byte_valid <= 1'b0;
        end else begin
            rx_done       <= 1'b0;
            rx_byte_valid <= rx_done;
            if (start || stop) begin
                bit_cnt <= '0;
            end else if (rx_shift_en) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= {rx_shift[6:0], mosi_s};
                if (bit_cnt == 3'd7) begin
                    rx_byte <= {rx_shift[6:0], mosi_s};
                    rx_done <= 1'b1;
                end
            end
        end
    end

    assign tx_next    = hold_full ? hold_data : TX_DEFAULT;
    assign hold_write = tx_byte_valid & ~hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift    <= '0;
            miso        <= 1'b0;
            selected    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= consume & ~hold_full;
            if (stop) begin
                miso     <= 1'b0;
                selected <= 1'b0;
            end else if (consume) begin
                tx_shift <= tx_next;
                miso     <= tx_next[7];
                if (start)
                    selected <= 1'b1;
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso     <= tx_shift[6];
            end
        end
    end

    // A write can only land while empty, so a same-cycle consume sees the
    // old (empty) content and the new byte stays held.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (hold_write) begin
            hold_data <= tx_byte;
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    assign tx_ready = ~hold_full;
    assign miso_oe  = selected;
    assign busy     = selected;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table vectors, hand-written corner sequences and
// randomized frames checked against a byte-level model of the transfer.
module tb_spi_slave;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso, miso_oe, tx_ready, rx_byte_valid, tx_underrun, busy;
    logic [7:0] tx_byte = '0;
    logic       tx_byte_valid = 1'b0;
    logic [7:0] rx_byte;

    int vectors = 0;
    int miscompares = 0;
    int rxv_cnt = 0;
    int udr_cnt = 0;
    int falls = 0;
    logic [7:0] rxq[$];
    logic [7:0] m_tx[4];
    logic [7:0] m_rx[4];

    typedef struct {
        bit         pre;
        logic [7:0] pre_byte;
        logic [7:0] mosi_b;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t tbl[4];

    spi_slave #(.SYNC_FLOPS(2), .TX_DEFAULT(8'hFF)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe), .tx_byte(tx_byte),
        .tx_byte_valid(tx_byte_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_byte_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rxq.push_back(rx_byte);
        end
        if (tx_underrun)
            udr_cnt <= udr_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        int t;
        t = 0;
        while (!tx_ready && t < 500) begin
            tick(1);
            t++;
        end
        if (!tx_ready)
            check("load_wait", 32'(tx_ready), 32'd1);
        tx_byte = b;
        tx_byte_valid = 1'b1;
        tick(1);
        tx_byte_valid = 1'b0;
    endtask

    // Mode-0 master: mosi changes with sclk low, miso sampled at sclk rise.
    // The last sclk fall coincides with ss_n rising unless keep_ss is set.
    task automatic spi_bits(input int nbits, input bit keep_ss);
        logic [7:0] b;
        sclk = 1'b0;
        ss_n = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            b = m_tx[i/8];
            mosi = b[7-(i%8)];
            tick(HALF);
            sclk = 1'b1;
            m_rx[i/8][7-(i%8)] = miso;
            tick(HALF);
            sclk = 1'b0;
            falls++;
            if (i == nbits - 1 && !keep_ss)
                ss_n = 1'b1;
        end
        mosi = 1'b0;
        tick(3 * HALF);
    endtask

    task automatic clear_m();
        for (int i = 0; i < 4; i++) m_rx[i] = '0;
    endtask

    initial begin
        int b_rx, b_udr, n, pre;
        logic [7:0] pb;
        logic [7:0] exp_q[$];

        tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5};
        tbl[1] = '{1'b0, 8'h00, 8'h81, 8'hFF};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{1'b1, 8'h5A, 8'hA5, 8'h5A};

        // Reset state
        tick(3);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_rx_valid", 32'(rx_byte_valid), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);

        // sclk activity while deselected is ignored
        b_rx = rxv_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) sclk = ~sclk;
            mosi = 1'($urandom);
            tick(1);
        end
        sclk = 1'b0;
        tick(5);
        check("idle_rxv", 32'(rxv_cnt - b_rx), 32'd0);
        check("idle_oe", 32'(miso_oe), 32'd0);
        check("idle_ready", 32'(tx_ready), 32'd1);

        // Single-byte table vectors
        for (int v = 0; v < 4; v++) begin
            clear_m();
            if (tbl[v].pre) begin
                load(tbl[v].pre_byte);
                check("load_ready_low", 32'(tx_ready), 32'd0);
            end
            b_rx = rxv_cnt;
            b_udr = udr_cnt;
            m_tx[0] = tbl[v].mosi_b;
            spi_bits(8, 1'b0);
            check("tbl_miso", 32'(m_rx[0]), 32'(tbl[v].exp_miso));
            check("tbl_rxv", 32'(rxv_cnt - b_rx), 32'd1);
            if (rxv_cnt > b_rx)
                check("tbl_rx", 32'(rxq[b_rx]), 32'(tbl[v].mosi_b));
            check("tbl_udr", 32'(udr_cnt - b_udr), tbl[v].pre ? 32'd0 : 32'd1);
            check("tbl_ready", 32'(tx_ready), 32'd1);
            check("tbl_oe", 32'(miso_oe), 32'd0);
            tick(10);
        end

        // Three-byte frame with a refill once the first byte is consumed
        clear_m();
        load(8'h11);
        b_rx = rxv_cnt;
        b_udr = udr_cnt;
        m_tx[0] = 8'hC3; m_tx[1] = 8'h5A; m_tx[2] = 8'h0F;
        fork
            spi_bits(24, 1'b0);
            load(8'h22);
        join
        check("m3_b0", 32'(m_rx[0]), 32'h11);
        check("m3_b1", 32'(m_rx[1]), 32'h22);
        check("m3_b2", 32'(m_rx[2]), 32'hFF);
        check("m3_udr", 32'(udr_cnt - b_udr), 32'd1);
        check("m3_rxv", 32'(rxv_cnt - b_rx), 32'd3);
        if (rxv_cnt - b_rx == 3) begin
            check("m3_rx0", 32'(rxq[b_rx]), 32'hC3);
            check("m3_rx1", 32'(rxq[b_rx+1]), 32'h5A);
            check("m3_rx2", 32'(rxq[b_rx+2]), 32'h0F);
        end
        tick(10);

        // Partial frame is discarded and the bit count restarts
        clear_m();
        b_rx = rxv_cnt;
        m_tx[0] = 8'hFF;
        spi_bits(5, 1'b0);
        check("part_rxv", 32'(rxv_cnt - b_rx), 32'd0);
        tick(10);
        m_tx[0] = 8'h81;
        spi_bits(8, 1'b0);
        check("part_next_rxv", 32'(rxv_cnt - b_rx), 32'd1);
        if (rxv_cnt > b_rx)
            check("part_next_rx", 32'(rxq[b_rx]), 32'h81);
        tick(10);

        // Write on the exact cycle of a byte-boundary consume
        clear_m();
        load(8'h11);
        b_udr = udr_cnt;
        falls = 0;
        m_tx[0] = 8'h00; m_tx[1] = 8'h00; m_tx[2] = 8'h00;
        fork
            spi_bits(24, 1'b0);
            begin
                int t;
                t = 0;
                while (falls < 8 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (falls < 8)
                    check("same_wait", 32'(falls), 32'd8);
                tick(2);
                tx_byte = 8'h77;
                tx_byte_valid = 1'b1;
                tick(1);
                tx_byte_valid = 1'b0;
                check("same_ready", 32'(tx_ready), 32'd0);
                check("same_udr_pulse", 32'(tx_underrun), 32'd1);
                tick(2);
                check("same_ready_hold", 32'(tx_ready), 32'd0);
            end
        join
        check("same_b0", 32'(m_rx[0]), 32'h11);
        check("same_b1", 32'(m_rx[1]), 32'hFF);
        check("same_b2", 32'(m_rx[2]), 32'h77);
        check("same_udr", 32'(udr_cnt - b_udr), 32'd1);
        tick(10);

        // Reset mid-frame after four bits
        clear_m();
        load(8'hC6);
        m_tx[0] = 8'hFF;
        spi_bits(4, 1'b1);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        tick(1);
        reset = 1'b0;
        check("mid_miso", 32'(miso), 32'd0);
        check("mid_oe", 32'(miso_oe), 32'd0);
        check("mid_busy0", 32'(busy), 32'd0);
        check("mid_ready", 32'(tx_ready), 32'd1);
        check("mid_rx_byte", 32'(rx_byte), 32'd0);
        check("mid_rxv", 32'(rx_byte_valid), 32'd0);
        check("mid_udr", 32'(tx_underrun), 32'd0);
        tick(10);
        clear_m();
        load(8'h3D);
        b_rx = rxv_cnt;
        m_tx[0] = 8'hE7;
        spi_bits(8, 1'b0);
        check("post_miso", 32'(m_rx[0]), 32'h3D);
        check("post_rxv", 32'(rxv_cnt - b_rx), 32'd1);
        if (rxv_cnt > b_rx)
            check("post_rx", 32'(rxq[b_rx]), 32'hE7);
        tick(10);

        // Randomized frames: only the first byte can come from the holding
        // register, every later byte is an underrun.
        for (int f = 0; f < 30; f++) begin
            clear_m();
            n = int'($urandom_range(1, 3));
            pre = int'($urandom_range(0, 1));
            pb = 8'($urandom);
            if (pre != 0) load(pb);
            exp_q.delete();
            for (int k = 0; k < n; k++) begin
                m_tx[k] = 8'($urandom);
                exp_q.push_back((k == 0 && pre != 0) ? pb : 8'hFF);
            end
            b_rx = rxv_cnt;
            b_udr = udr_cnt;
            spi_bits(8 * n, 1'b0);
            for (int k = 0; k < n; k++)
                check("rnd_miso", 32'(m_rx[k]), 32'(exp_q[k]));
            check("rnd_rxv", 32'(rxv_cnt - b_rx), 32'(n));
            if (rxv_cnt - b_rx == n)
                for (int k = 0; k < n; k++)
                    check("rnd_rx", 32'(rxq[b_rx+k]), 32'(m_tx[k]));
            check("rnd_udr", 32'(udr_cnt - b_udr), 32'(n - 1 + (pre == 0 ? 1 : 0)));
            tick(int'($urandom_range(5, 20)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
